// File: rtl/fp_divider_seq.sv
// rtl/fp_divider_seq.sv - sequential binary32 divider: restoring mantissa division, one bit per clock, RNE rounding
module fp_divider_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic        invalid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_NORM   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [4:0]  ITERATIONS = 5'd26;
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [23:0]       mb_q, mb_d;
    logic [24:0]       rem_q, rem_d;
    logic [25:0]       quo_q, quo_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;
    logic              dbz_q, dbz_d;
    logic              inv_q, inv_d;

    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        op_sign;

    // Denormal inputs fall into the zero class.
    always_comb begin
        ea      = a[30:23];
        eb      = b[30:23];
        fa      = a[22:0];
        fb      = b[22:0];
        a_nan   = (ea == 8'hFF) && (fa != 23'd0);
        b_nan   = (eb == 8'hFF) && (fb != 23'd0);
        a_inf   = (ea == 8'hFF) && (fa == 23'd0);
        b_inf   = (eb == 8'hFF) && (fb == 23'd0);
        a_zero  = (ea == 8'h00);
        b_zero  = (eb == 8'h00);
        op_sign = a[31] ^ b[31];
    end

    logic        is_special;
    logic [31:0] spec_result;
    logic        spec_dbz;
    logic        spec_inv;

    always_comb begin
        is_special  = 1'b1;
        spec_result = QNAN;
        spec_dbz    = 1'b0;
        spec_inv    = 1'b0;
        if (a_nan || b_nan) begin
            spec_inv = 1'b1;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            spec_inv = 1'b1;
        end else if (b_zero) begin
            spec_result = {op_sign, 8'hFF, 23'd0};
            spec_dbz    = 1'b1;
        end else if (a_inf) begin
            spec_result = {op_sign, 8'hFF, 23'd0};
        end else if (b_inf || a_zero) begin
            spec_result = {op_sign, 31'd0};
        end else begin
            is_special  = 1'b0;
            spec_result = 32'd0;
        end
    end

    // Partial remainder stays below 2*mb, so one trial subtract per bit suffices.
    logic [25:0] trial;
    logic        q_bit;
    logic [24:0] rem_next;

    always_comb begin
        trial    = {1'b0, rem_q} - {2'b00, mb_q};
        q_bit    = ~trial[25];
        rem_next = (q_bit ? trial[24:0] : rem_q) << 1;
    end

    logic [22:0]       frac_pre;
    logic [22:0]       frac_rnd;
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic              rnd_carry;
    logic signed [9:0] exp_adj;
    logic signed [9:0] exp_fin;
    logic [31:0]       norm_result;

    always_comb begin
        if (quo_q[25]) begin
            frac_pre = quo_q[24:2];
            guard    = quo_q[1];
            sticky   = quo_q[0] | (|rem_q);
            exp_adj  = exp_q;
        end else begin
            frac_pre = quo_q[23:1];
            guard    = quo_q[0];
            sticky   = |rem_q;
            exp_adj  = exp_q - 10'sd1;
        end
        round_up = guard & (sticky | frac_pre[0]);
        // A carry out of the fraction means the significand became exactly 2.0.
        {rnd_carry, frac_rnd} = {1'b0, frac_pre} + {23'd0, round_up};
        exp_fin = rnd_carry ? (exp_adj + 10'sd1) : exp_adj;
        if (exp_fin >= 10'sd255) begin
            norm_result = {sign_q, 8'hFF, 23'd0};
        end else if (exp_fin <= 10'sd0) begin
            norm_result = {sign_q, 31'd0};
        end else begin
            norm_result = {sign_q, exp_fin[7:0], frac_rnd};
        end
    end

    // DONE also accepts start so back-to-back operations lose no cycle.
    logic accept;

    always_comb begin
        accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = is_special ? S_DONE : S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (cnt_q == 5'd1) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (accept) begin
                    state_d = is_special ? S_DONE : S_DIVIDE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        sign_d   = sign_q;
        exp_d    = exp_q;
        mb_d     = mb_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        inv_d    = inv_q;
        if (accept) begin
            if (is_special) begin
                result_d = spec_result;
                dbz_d    = spec_dbz;
                inv_d    = spec_inv;
            end else begin
                sign_d = op_sign;
                exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
                mb_d   = {1'b1, fb};
                rem_d  = {2'b01, fa};
                quo_d  = 26'd0;
                cnt_d  = ITERATIONS;
            end
        end else if (state_q == S_DIVIDE) begin
            rem_d = rem_next;
            quo_d = {quo_q[24:0], q_bit};
            cnt_d = cnt_q - 5'd1;
        end else if (state_q == S_NORM) begin
            result_d = norm_result;
            dbz_d    = 1'b0;
            inv_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sign_q   <= 1'b0;
            exp_q    <= 10'sd0;
            mb_q     <= 24'd0;
            rem_q    <= 25'd0;
            quo_q    <= 26'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            dbz_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mb_q     <= mb_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
            inv_q    <= inv_d;
        end
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        result      = result_q;
        div_by_zero = dbz_q;
        invalid     = inv_q;
    end

endmodule
